cp0_int_ctrl: RTL and testbench
===============================

Name: cp0_int_ctrl

Overview:
Parametrised coprocessor-0 interrupt and exception-return controller for the 5-stage pipelined CPU. It latches N external interrupt lines and arbitrates them against Status mask/IE. When an interrupt is taken, it captures the ID-stage PC into EPC, flushes IF/ID and redirects fetch to a (optionally vectored) handler. It executes eret by redirecting to EPC, and exposes Status/Cause/EPC to mfc0/mtc0 through a register port.

Parameters:
N_INT, 4, number of interrupt lines (legal 1..8)
AW, 32, PC/address width
HANDLER_BASE, 32'h0000_0040, handler address (vector 0)
VECTORED, 0, 0 = single handler entry; 1 = HANDLER_BASE + idx*VEC_STRIDE
VEC_STRIDE, 32'h10, byte spacing of vectored entries

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
int_req  in  N_INT  level interrupt requests, synchronous to clk
id_valid  in  1  ID holds a real instruction (not bubble)
stall_id  in  1  ID stalled this cycle (hazard); blocks take/eret
eret_id  in  1  instruction in ID decodes as eret
pc_id  in  AW  PC of instruction in ID
cp0_we  in  1  mtc0 write strobe
cp0_addr  in  5  CP0 register number (12 Status, 13 Cause, 14 EPC)
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  combinational read of cp0_addr; 0 for other numbers
redirect  out  1  fetch redirect this cycle
redirect_pc  out  AW  target when redirect=1, else 0
flush_if  out  1  kill IF/ID register contents
flush_id  out  1  kill ID/EX register contents (insert bubble)
int_ack  out  N_INT  one-hot acknowledge of taken line
in_handler  out  1  state == HANDLER

Behaviour:
- Registers: Status{mask[8+N_INT-1:8], IE[0]}, Cause{pend[8+N_INT-1:8], code[6:2]}, EPC[AW-1:0], prev[N_INT-1:0], state.
- Reset (async): state=IDLE; Status=0; Cause=0; EPC=0; prev=0. All outputs 0; cp0_rdata reflects the zeroed registers.
- Edge latch: rise[i] = int_req[i] & ~prev[i]; prev <= int_req each cycle. pend[i] is set on rise[i] and cleared by int_ack[i] or by an mtc0 Cause write of 0 to that bit. If set and clear occur in the same cycle, set wins. A line held high across reset release produces a pending bit 1 cycle after release.
- take = (state==IDLE) & IE & |(pend & mask) & id_valid & ~stall_id & ~eret_id.
- Priority: lowest index wins.
- Take cycle (outputs Mealy/combinational; registers update at the following edge):
  - redirect=1, flush_if=1, flush_id=1, int_ack[idx]=1.
  - redirect_pc = HANDLER_BASE, or HANDLER_BASE+idx*VEC_STRIDE when VECTORED=1.
  - Next edge: EPC<=pc_id (the ID instruction is discarded and re-executed on return), IE<=0, code<=idx, state<=HANDLER.
- HANDLER: no interrupt is taken regardless of IE or pend (no nesting). Pending bits keep latching.
  - eret cycle (eret_id & id_valid & ~stall_id): redirect=1, redirect_pc=EPC, flush_if=1, flush_id=1. Next edge: IE<=1, state<=IDLE.
- eret_id in IDLE: ignored (no redirect, no flush).
- Stall: while stall_id=1, take/eret are deferred; pending state is retained.
- mtc0 (cp0_we):
  - Writes Status mask/IE, Cause pend bits (clear-only) or EPC. Other bits are read-only, read as 0.
  - Same-cycle hardware update (take/eret) overrides software write on IE, EPC and code; the mask write still lands.
- redirect_pc width: address arithmetic is modulo 2^AW.
- Reset asserted mid-handler: immediate return to IDLE with all state cleared; no redirect is emitted.

Decomposition:
- Package cp0_pkg: CP0 register numbers (12/13/14), Status/Cause bit positions, state enum {IDLE, HANDLER}.
- Sub-module int_edge_latch (prev register, rise detect, pend set/clear with set-priority), parametrised by N_INT.
- Arbiter, FSM and register file stay in cp0_int_ctrl.

Test Plan:
1. After reset: mtc0 Status=0x0000_0F01; pulse int_req=4'b0100 with id_valid=1, pc_id=0x0000_0120 -> 1 cycle later redirect=1, redirect_pc=0x40, int_ack=4'b0100, flush_if=flush_id=1. Afterwards EPC=0x120, Cause.code=2, IE=0, in_handler=1.
2. In HANDLER, eret_id=1, id_valid=1 -> redirect=1, redirect_pc=0x120. Next cycle in_handler=0, Status=0x0F01.
3. VECTORED=1: int_req lines 1 and 3 rise in the same cycle, Status=0x0F01 -> int_ack=4'b0010, redirect_pc=0x50. After eret, line 3 is taken with redirect_pc=0x70.
4. Mask=0 (Status=0x0001), int_req[0] rises -> no redirect, Cause=0x0000_0100. Then mtc0 Status=0x0101 -> take occurs on the next cycle with id_valid=1.
5. stall_id=1 for 3 cycles with a pending enabled interrupt -> no redirect during the stall. Take occurs on the first cycle stall_id=0, and EPC equals pc_id in that cycle.
6. Assert reset while in_handler=1, with int_req[0] held high through release -> all outputs 0 during reset. pend[0]=1 one cycle after release; IE=0, so no redirect.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, Status/Cause field positions and controller state type
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int STATUS_IE_BIT   = 0;
    localparam int STATUS_MASK_LSB = 8;
    localparam int CAUSE_CODE_LSB  = 2;
    localparam int CAUSE_CODE_W    = 5;
    localparam int CAUSE_PEND_LSB  = 8;

    // Interrupt index width: enough for up to 8 lines.
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } cp0State_t;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// rtl/cp0_int_ctrl_if.sv - pipeline-side and CP0 register port bundle of the interrupt controller
interface cp0_int_ctrl_if #(
    parameter int N_INT = 4,
    parameter int AW    = 32
);

    logic [N_INT-1:0] int_req;
    logic             id_valid;
    logic             stall_id;
    logic             eret_id;
    logic [AW-1:0]    pc_id;
    logic             cp0_we;
    logic [4:0]       cp0_addr;
    logic [31:0]      cp0_wdata;
    logic [31:0]      cp0_rdata;
    logic             redirect;
    logic [AW-1:0]    redirect_pc;
    logic             flush_if;
    logic             flush_id;
    logic [N_INT-1:0] int_ack;
    logic             in_handler;

    modport master (
        output int_req, id_valid, stall_id, eret_id, pc_id,
        output cp0_we, cp0_addr, cp0_wdata,
        input  cp0_rdata, redirect, redirect_pc, flush_if, flush_id, int_ack, in_handler
    );

    modport slave (
        input  int_req, id_valid, stall_id, eret_id, pc_id,
        input  cp0_we, cp0_addr, cp0_wdata,
        output cp0_rdata, redirect, redirect_pc, flush_if, flush_id, int_ack, in_handler
    );

endinterface

// File: rtl/cp0_int_ctrl_edge_latch.sv
// rtl/cp0_int_ctrl_edge_latch.sv - rising-edge detect and pending latch for interrupt lines
module int_edge_latch #(
    parameter int N_INT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_INT-1:0] intReq,
    input  logic [N_INT-1:0] clrMask,
    output logic [N_INT-1:0] pend
);

    logic [N_INT-1:0] prevReq;
    logic [N_INT-1:0] rise;

    assign rise = intReq & ~prevReq;

    // A new edge beats a clear arriving in the same cycle, so no request is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prevReq <= '0;
            pend    <= '0;
        end else begin
            prevReq <= intReq;
            pend    <= (pend & ~clrMask) | rise;
        end
    end

endmodule

// File: rtl/cp0_int_ctrl.sv
// rtl/cp0_int_ctrl.sv - CP0 interrupt arbitration, take/eret redirect and Status/Cause/EPC registers
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter int          N_INT        = 4,
    parameter int          AW           = 32,
    parameter logic [31:0] HANDLER_BASE = 32'h0000_0040,
    parameter bit          VECTORED     = 1'b0,
    parameter logic [31:0] VEC_STRIDE   = 32'h10
) (
    input  logic          clk,
    input  logic          reset,
    cp0_int_ctrl_if.slave bus
);

    cp0State_t                state;
    cp0State_t                stateNext;
    logic [N_INT-1:0]         statusMask;
    logic                     statusIe;
    logic [CAUSE_CODE_W-1:0]  causeCode;
    logic [AW-1:0]            epc;
    logic [N_INT-1:0]         pend;

    logic [N_INT-1:0]         active;
    logic [IDX_W-1:0]         takeIdx;
    logic                     take;
    logic                     eretFire;
    logic [N_INT-1:0]         ackOh;
    logic [N_INT-1:0]         swClr;
    logic [AW-1:0]            handlerPc;
    logic                     redirect;
    logic [AW-1:0]            redirectPc;
    logic                     flush;
    logic                     wrStatus;
    logic                     wrCause;
    logic                     wrEpc;
    logic [31:0]              rdata;

    assign wrStatus = bus.cp0_we && (bus.cp0_addr == CP0_STATUS);
    assign wrCause  = bus.cp0_we && (bus.cp0_addr == CP0_CAUSE);
    assign wrEpc    = bus.cp0_we && (bus.cp0_addr == CP0_EPC);

    // Software can only clear pending bits: a 0 written to a pend bit clears it.
    assign swClr = wrCause ? ~bus.cp0_wdata[CAUSE_PEND_LSB +: N_INT] : '0;

    int_edge_latch #(
        .N_INT (N_INT)
    ) u_edge_latch (
        .clk     (clk),
        .reset   (reset),
        .intReq  (bus.int_req),
        .clrMask (swClr | ackOh),
        .pend    (pend)
    );

    assign active = pend & statusMask;

    always_comb begin
        takeIdx = '0;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (active[i]) begin
                takeIdx = IDX_W'(i);
            end
        end
    end

    assign take = (state == IDLE) && statusIe && (|active) && bus.id_valid
                  && !bus.stall_id && !bus.eret_id;
    assign eretFire = (state == HANDLER) && bus.eret_id && bus.id_valid && !bus.stall_id;

    assign ackOh = take ? (N_INT'(1) << takeIdx) : '0;

    generate
        if (VECTORED) begin : g_vectored
            assign handlerPc = AW'(HANDLER_BASE) + (AW'(takeIdx) * AW'(VEC_STRIDE));
        end else begin : g_single
            assign handlerPc = AW'(HANDLER_BASE);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        redirect   = 1'b0;
        redirectPc = '0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    redirect   = 1'b1;
                    redirectPc = handlerPc;
                    flush      = 1'b1;
                    stateNext  = HANDLER;
                end
            end
            HANDLER: begin
                if (eretFire) begin
                    redirect   = 1'b1;
                    redirectPc = epc;
                    flush      = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Hardware take/eret is written last so it wins over an mtc0 in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            statusMask <= '0;
            statusIe   <= 1'b0;
            causeCode  <= '0;
            epc        <= '0;
        end else begin
            if (wrStatus) begin
                statusMask <= bus.cp0_wdata[STATUS_MASK_LSB +: N_INT];
                statusIe   <= bus.cp0_wdata[STATUS_IE_BIT];
            end
            if (wrEpc) begin
                epc <= AW'(bus.cp0_wdata);
            end
            if (take) begin
                epc       <= bus.pc_id;
                statusIe  <= 1'b0;
                causeCode <= CAUSE_CODE_W'(takeIdx);
            end else if (eretFire) begin
                statusIe <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.cp0_addr)
            CP0_STATUS: begin
                rdata[STATUS_MASK_LSB +: N_INT] = statusMask;
                rdata[STATUS_IE_BIT]            = statusIe;
            end
            CP0_CAUSE: begin
                rdata[CAUSE_PEND_LSB +: N_INT]        = pend;
                rdata[CAUSE_CODE_LSB +: CAUSE_CODE_W] = causeCode;
            end
            CP0_EPC:  rdata = 32'(epc);
            default:  rdata = '0;
        endcase
    end

    assign bus.cp0_rdata   = rdata;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirectPc;
    assign bus.flush_if    = flush;
    assign bus.flush_id    = flush;
    assign bus.int_ack     = ackOh;
    assign bus.in_handler  = (state == HANDLER);

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb/tb_cp0_int_ctrl.sv - directed vector bench for single-entry and vectored controller instances
module tb_cp0_int_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nCmp = 0;
    int   nBad = 0;

    always #5 clk = ~clk;

    cp0_int_ctrl_if #(.N_INT(4), .AW(32)) busA ();
    cp0_int_ctrl_if #(.N_INT(4), .AW(32)) busB ();

    cp0_int_ctrl #(.N_INT(4), .AW(32), .HANDLER_BASE(32'h40), .VECTORED(1'b0), .VEC_STRIDE(32'h10))
        dutA (.clk(clk), .reset(reset), .bus(busA));
    cp0_int_ctrl #(.N_INT(4), .AW(32), .HANDLER_BASE(32'h40), .VECTORED(1'b1), .VEC_STRIDE(32'h10))
        dutB (.clk(clk), .reset(reset), .bus(busB));

    typedef struct {
        logic [3:0]  req;
        logic        vld;
        logic        stl;
        logic        ert;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        rd;
        logic [31:0] pcA;
        logic [31:0] pcB;
        logic [3:0]  ack;
        logic        inH;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [3:0] req, input logic vld, input logic stl,
                                input logic ert, input logic [31:0] pc, input logic we,
                                input logic [4:0] addr, input logic [31:0] wd, input logic rd,
                                input logic [31:0] pcA, input logic [31:0] pcB,
                                input logic [3:0] ack, input logic inH, input logic [31:0] rdata);
        vec_t v;
        v.req = req; v.vld = vld; v.stl = stl; v.ert = ert; v.pc = pc; v.we = we;
        v.addr = addr; v.wd = wd; v.rd = rd; v.pcA = pcA; v.pcB = pcB; v.ack = ack;
        v.inH = inH; v.rdata = rdata;
        return v;
    endfunction

    task automatic drive(input logic [3:0] req, input logic vld, input logic stl, input logic ert,
                         input logic [31:0] pc, input logic we, input logic [4:0] addr,
                         input logic [31:0] wd);
        busA.int_req = req;  busB.int_req = req;
        busA.id_valid = vld; busB.id_valid = vld;
        busA.stall_id = stl; busB.stall_id = stl;
        busA.eret_id = ert;  busB.eret_id = ert;
        busA.pc_id = pc;     busB.pc_id = pc;
        busA.cp0_we = we;    busB.cp0_we = we;
        busA.cp0_addr = addr; busB.cp0_addr = addr;
        busA.cp0_wdata = wd; busB.cp0_wdata = wd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic rd, input logic [31:0] pcA,
                          input logic [31:0] pcB, input logic [3:0] ack, input logic inH,
                          input logic [31:0] rdata);
        chk({tag, " A.redirect"}, 32'(busA.redirect), 32'(rd));
        chk({tag, " A.redirect_pc"}, busA.redirect_pc, pcA);
        chk({tag, " A.flush_if"}, 32'(busA.flush_if), 32'(rd));
        chk({tag, " A.flush_id"}, 32'(busA.flush_id), 32'(rd));
        chk({tag, " A.int_ack"}, 32'(busA.int_ack), 32'(ack));
        chk({tag, " A.in_handler"}, 32'(busA.in_handler), 32'(inH));
        chk({tag, " A.cp0_rdata"}, busA.cp0_rdata, rdata);
        chk({tag, " B.redirect"}, 32'(busB.redirect), 32'(rd));
        chk({tag, " B.redirect_pc"}, busB.redirect_pc, pcB);
        chk({tag, " B.flush_if"}, 32'(busB.flush_if), 32'(rd));
        chk({tag, " B.flush_id"}, 32'(busB.flush_id), 32'(rd));
        chk({tag, " B.int_ack"}, 32'(busB.int_ack), 32'(ack));
        chk({tag, " B.in_handler"}, 32'(busB.in_handler), 32'(inH));
        chk({tag, " B.cp0_rdata"}, busB.cp0_rdata, rdata);
    endtask

    initial begin
        // reset check, take, eret
        vecs[0]  = mk(4'b0000, 1, 0, 0, 32'h100, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h0);
        vecs[1]  = mk(4'b0000, 1, 0, 0, 32'h100, 0, 5'd14, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h0);
        vecs[2]  = mk(4'b0000, 1, 0, 0, 32'h100, 1, 5'd12, 32'hF01, 0, 32'h0,   32'h0,   4'b0000, 0, 32'h0);
        vecs[3]  = mk(4'b0100, 1, 0, 0, 32'h120, 0, 5'd12, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'hF01);
        vecs[4]  = mk(4'b0000, 1, 0, 0, 32'h120, 0, 5'd13, 32'h0,   1, 32'h40,  32'h60,  4'b0100, 0, 32'h400);
        vecs[5]  = mk(4'b0000, 1, 0, 0, 32'h124, 0, 5'd14, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h120);
        vecs[6]  = mk(4'b0000, 1, 0, 0, 32'h124, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h8);
        vecs[7]  = mk(4'b0000, 1, 0, 0, 32'h124, 0, 5'd12, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'hF00);
        vecs[8]  = mk(4'b0000, 1, 0, 1, 32'h128, 0, 5'd12, 32'h0,   1, 32'h120, 32'h120, 4'b0000, 1, 32'hF00);
        vecs[9]  = mk(4'b0000, 1, 0, 0, 32'h120, 0, 5'd12, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'hF01);
        // simultaneous lines 1 and 3: priority and vectoring
        vecs[10] = mk(4'b1010, 1, 0, 0, 32'h200, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h8);
        vecs[11] = mk(4'b1010, 1, 0, 0, 32'h200, 0, 5'd13, 32'h0,   1, 32'h40,  32'h50,  4'b0010, 0, 32'hA08);
        vecs[12] = mk(4'b0000, 1, 0, 0, 32'h204, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h804);
        vecs[13] = mk(4'b0000, 1, 0, 1, 32'h208, 0, 5'd13, 32'h0,   1, 32'h200, 32'h200, 4'b0000, 1, 32'h804);
        vecs[14] = mk(4'b0000, 1, 0, 0, 32'h300, 0, 5'd14, 32'h0,   1, 32'h40,  32'h70,  4'b1000, 0, 32'h200);
        vecs[15] = mk(4'b0000, 1, 0, 0, 32'h304, 0, 5'd14, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h300);
        vecs[16] = mk(4'b0000, 1, 0, 1, 32'h308, 0, 5'd14, 32'h0,   1, 32'h300, 32'h300, 4'b0000, 1, 32'h300);
        vecs[17] = mk(4'b0000, 1, 0, 0, 32'h300, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'hC);
        // masked line, then unmask
        vecs[18] = mk(4'b0000, 1, 0, 0, 32'h300, 1, 5'd12, 32'h1,   0, 32'h0,   32'h0,   4'b0000, 0, 32'hF01);
        vecs[19] = mk(4'b0001, 1, 0, 0, 32'h300, 0, 5'd12, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h1);
        vecs[20] = mk(4'b0001, 1, 0, 0, 32'h300, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h10C);
        vecs[21] = mk(4'b0000, 1, 0, 0, 32'h300, 1, 5'd12, 32'h101, 0, 32'h0,   32'h0,   4'b0000, 0, 32'h1);
        vecs[22] = mk(4'b0000, 1, 0, 0, 32'h400, 0, 5'd12, 32'h0,   1, 32'h40,  32'h40,  4'b0001, 0, 32'h101);
        vecs[23] = mk(4'b0000, 1, 0, 0, 32'h404, 0, 5'd12, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h100);
        // eret with concurrent mtc0 Status: IE from hardware, mask from software
        vecs[24] = mk(4'b0000, 1, 0, 1, 32'h408, 1, 5'd12, 32'hF00, 1, 32'h400, 32'h400, 4'b0000, 1, 32'h100);
        vecs[25] = mk(4'b0000, 1, 0, 0, 32'h400, 0, 5'd12, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'hF01);
        // stall and bubble defer the take
        vecs[26] = mk(4'b0100, 1, 0, 0, 32'h500, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h0);
        vecs[27] = mk(4'b0000, 1, 1, 0, 32'h504, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h400);
        vecs[28] = mk(4'b0000, 1, 1, 0, 32'h504, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h400);
        vecs[29] = mk(4'b0000, 0, 0, 0, 32'h504, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 0, 32'h400);
        vecs[30] = mk(4'b0000, 1, 0, 0, 32'h508, 0, 5'd13, 32'h0,   1, 32'h40,  32'h60,  4'b0100, 0, 32'h400);
        vecs[31] = mk(4'b0000, 1, 0, 0, 32'h50C, 0, 5'd14, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h508);
        // pending latches in handler; clear-only Cause writes; set beats clear
        vecs[32] = mk(4'b0011, 1, 0, 0, 32'h510, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h8);
        vecs[33] = mk(4'b0011, 1, 0, 0, 32'h510, 1, 5'd13, 32'h200, 0, 32'h0,   32'h0,   4'b0000, 1, 32'h308);
        vecs[34] = mk(4'b0111, 1, 0, 0, 32'h510, 1, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h208);
        vecs[35] = mk(4'b0000, 1, 0, 0, 32'h510, 0, 5'd13, 32'h0,   0, 32'h0,   32'h0,   4'b0000, 1, 32'h408);

        drive(4'b0000, 0, 0, 0, 32'h0, 0, 5'd12, 32'h0);
        @(negedge clk);
        #1;
        chkAll("in_reset", 0, 32'h0, 32'h0, 4'b0000, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].vld, vecs[i].stl, vecs[i].ert, vecs[i].pc,
                  vecs[i].we, vecs[i].addr, vecs[i].wd);
            #1;
            chkAll($sformatf("v%0d", i), vecs[i].rd, vecs[i].pcA, vecs[i].pcB, vecs[i].ack,
                   vecs[i].inH, vecs[i].rdata);
        end

        // Reset mid-handler with line 0 held high through release.
        @(negedge clk);
        drive(4'b0001, 1, 0, 0, 32'h600, 0, 5'd13, 32'h0);
        reset = 1'b1;
        #1;
        chkAll("mid_reset", 0, 32'h0, 32'h0, 4'b0000, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chkAll("release", 0, 32'h0, 32'h0, 4'b0000, 0, 32'h0);
        @(negedge clk);
        #1;
        chkAll("post_release", 0, 32'h0, 32'h0, 4'b0000, 0, 32'h100);
        @(negedge clk);
        drive(4'b0001, 1, 0, 0, 32'h600, 0, 5'd12, 32'h0);
        #1;
        chkAll("status_zero", 0, 32'h0, 32'h0, 4'b0000, 0, 32'h0);
        // eret while idle is ignored
        @(negedge clk);
        drive(4'b0001, 1, 0, 1, 32'h604, 0, 5'd13, 32'h0);
        #1;
        chkAll("eret_idle", 0, 32'h0, 32'h0, 4'b0000, 0, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
